// File: rtl/bw_io_ddr_pkg.sv
// Shared types and constants for the DDR byte-lane sequencer.
// Burst beat counts are in rclk cycles (two DDR beats per cycle).
package bw_io_ddr_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WPRE,
        WDATA,
        WPOST,
        RWAIT,
        RDATA,
        CUPD
    } state_e;

    localparam int BEATS_BL4 = 2;
    localparam int BEATS_BL8 = 4;
    localparam int LPF_W     = 5;
    localparam int PTR_W     = 2;
    localparam int CNT_W     = 3;

    function automatic logic [CNT_W-1:0] beats_m1(input logic bl4);
        return bl4 ? CNT_W'(BEATS_BL4 - 1) : CNT_W'(BEATS_BL8 - 1);
    endfunction

endpackage

// File: rtl/bw_io_ddr_lane_seq_if.sv
// Burst command handshake between the DRAM controller and the lane sequencer.
// The controller is master; the sequencer answers with cmd_ready.
interface bw_io_ddr_lane_seq_if;

    logic cmd_valid;
    logic cmd_ready;
    logic cmd_wr;
    logic cmd_bl4;

    modport master (
        output cmd_valid,
        output cmd_wr,
        output cmd_bl4,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_wr,
        input  cmd_bl4,
        output cmd_ready
    );

endinterface

// File: rtl/bw_io_ddr_code_upd.sv
// Master-DLL code holding register and idle-gap qualifier.
// A code is applied only after IDLE_MIN quiet cycles so no DQS edge sees it move.
module bw_io_ddr_code_upd
    import bw_io_ddr_pkg::*;
#(
    parameter int IDLE_MIN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             idle,
    input  logic             cmd_fire,
    input  logic             code_vld,
    input  logic [LPF_W-1:0] code_in,
    output logic [LPF_W-1:0] code_out,
    output logic             pending,
    output logic             upd_go
);

    localparam logic [3:0] IDLE_MIN_C = 4'(IDLE_MIN);

    logic [3:0]       idle_cnt_q, idle_cnt_d;
    logic             pending_q, pending_d;
    logic [LPF_W-1:0] pend_code_q, pend_code_d;
    logic [LPF_W-1:0] code_q, code_d;

    assign upd_go   = idle & pending_q & (idle_cnt_q >= IDLE_MIN_C);
    assign code_out = code_q;
    assign pending  = pending_q;

    always_comb begin
        idle_cnt_d  = idle_cnt_q;
        pending_d   = pending_q;
        pend_code_d = pend_code_q;
        code_d      = code_q;
        if (!idle || upd_go || cmd_fire) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != 4'hF) begin
            idle_cnt_d = idle_cnt_q + 4'd1;
        end
        if (upd_go) begin
            code_d    = pend_code_q;
            pending_d = 1'b0;
        end
        // A code arriving on the apply edge is kept for the next gap.
        if (code_vld) begin
            pend_code_d = code_in;
            pending_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt_q  <= '0;
            pending_q   <= 1'b0;
            pend_code_q <= '0;
            code_q      <= '0;
        end else begin
            idle_cnt_q  <= idle_cnt_d;
            pending_q   <= pending_d;
            pend_code_q <= pend_code_d;
            code_q      <= code_d;
        end
    end

endmodule

// File: rtl/bw_io_ddr_lane_seq.sv
// Per-lane burst sequencer: turns write/read commands into pad control
// and schedules slave delay-line code loads into idle gaps.
module bw_io_ddr_lane_seq
    import bw_io_ddr_pkg::*;
#(
    parameter int WR_PRE   = 1,
    parameter int WR_POST  = 1,
    parameter int RD_LAT   = 3,
    parameter int IDLE_MIN = 4,
    parameter int STROBE_W = 2
) (
    input  logic                  rclk,
    input  logic                  arst,
    bw_io_ddr_lane_seq_if.slave   cmd,
    input  logic                  lpf_code_vld,
    input  logic [LPF_W-1:0]      lpf_code_in,
    output logic [LPF_W-1:0]      lpf_code,
    output logic                  strobe,
    output logic                  code_pending,
    output logic                  dram_io_pad_enable,
    output logic                  dram_io_drive_enable,
    output logic                  burst_length_four,
    output logic [PTR_W-1:0]      pad_pos_cnt,
    output logic [PTR_W-1:0]      pad_neg_cnt,
    output logic                  rd_capture_en,
    output logic                  busy
);

    localparam logic [CNT_W-1:0] PRE_M1  = CNT_W'(WR_PRE - 1);
    localparam logic [CNT_W-1:0] POST_M1 = CNT_W'(WR_POST - 1);
    localparam logic [CNT_W-1:0] RLAT_M1 = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] STRB_M1 = CNT_W'(STROBE_W - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bl4_q, bl4_d;
    logic [PTR_W-1:0] pos_q, pos_d;
    logic [PTR_W-1:0] neg_q, neg_d;
    logic [CNT_W-1:0] len_m1;
    logic             is_idle;
    logic             upd_go;
    logic             cmd_fire;
    logic             last;

    assign is_idle       = (state_q == IDLE);
    assign cmd.cmd_ready = is_idle & ~upd_go;
    assign cmd_fire      = cmd.cmd_valid & cmd.cmd_ready;
    assign last          = (cnt_q == len_m1);

    bw_io_ddr_code_upd #(
        .IDLE_MIN (IDLE_MIN)
    ) u_code_upd (
        .clk      (rclk),
        .rst      (arst),
        .idle     (is_idle),
        .cmd_fire (cmd_fire),
        .code_vld (lpf_code_vld),
        .code_in  (lpf_code_in),
        .code_out (lpf_code),
        .pending  (code_pending),
        .upd_go   (upd_go)
    );

    always_comb begin
        len_m1 = '0;
        unique case (state_q)
            WPRE:         len_m1 = PRE_M1;
            WDATA, RDATA: len_m1 = beats_m1(bl4_q);
            WPOST:        len_m1 = POST_M1;
            RWAIT:        len_m1 = RLAT_M1;
            CUPD:         len_m1 = STRB_M1;
            default:      len_m1 = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        bl4_d   = bl4_q;
        pos_d   = pos_q;
        neg_d   = neg_q;
        unique case (state_q)
            IDLE: begin
                if (upd_go) begin
                    state_d = CUPD;
                end else if (cmd_fire) begin
                    bl4_d   = cmd.cmd_bl4;
                    state_d = cmd.cmd_wr ? WPRE : RWAIT;
                end
            end
            WPRE:  if (last) state_d = WDATA;
            WDATA: begin
                pos_d = pos_q + 1'b1;
                neg_d = neg_q + 1'b1;
                if (last) state_d = WPOST;
            end
            WPOST: if (last) state_d = IDLE;
            RWAIT: if (last) state_d = RDATA;
            RDATA: if (last) state_d = IDLE;
            CUPD:  if (last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // One counter times every state; it restarts on each transition.
        if (state_d != state_q || is_idle) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge rclk or posedge arst) begin
        if (arst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bl4_q   <= 1'b1;
            pos_q   <= '0;
            neg_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bl4_q   <= bl4_d;
            pos_q   <= pos_d;
            neg_q   <= neg_d;
        end
    end

    assign dram_io_pad_enable   = state_q inside {WPRE, WDATA, WPOST, RWAIT, RDATA};
    assign dram_io_drive_enable = state_q inside {WPRE, WDATA, WPOST};
    assign rd_capture_en        = (state_q == RDATA);
    assign strobe               = (state_q == CUPD);
    assign busy                 = ~is_idle;
    assign burst_length_four    = bl4_q;
    assign pad_pos_cnt          = pos_q;
    assign pad_neg_cnt          = neg_q;

endmodule

// File: doc/bw_io_ddr_lane_seq.md
Name: bw_io_ddr_lane_seq

Overview:
Per-lane sequencer for a quad DDR byte-lane I/O group.
- Turns write/read burst commands into cycle-accurate pad control: dram_io_pad_enable, dram_io_drive_enable, pad_pos_cnt/pad_neg_cnt write pointers, burst_length_four and a read-capture window.
- Schedules master-DLL lpf_code updates into the slave delay lines. The code changes, and strobe pulses, only after a guaranteed idle gap, so no DQS edge is in flight while the code changes.
- Sits between the DRAM controller command path and one half (left or right) of the lane I/O group.

Parameters:
WR_PRE, 1, write preamble cycles (drive enabled before data), range 1-3
WR_POST, 1, write postamble cycles, range 1-3
RD_LAT, 3, cycles from read accept to first capture cycle minus 1, range 1-7
IDLE_MIN, 4, consecutive IDLE cycles required before a code update, range 2-15
STROBE_W, 2, strobe pulse width in cycles, range 1-3

Ports:
rclk  in  1  lane clock
arst  in  1  asynchronous reset, active-high
cmd_valid  in  1  burst command request
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready at rclk edge
cmd_wr  in  1  1=write, 0=read
cmd_bl4  in  1  1=BL4 (2 rclk data cycles), 0=BL8 (4 cycles)
lpf_code_vld  in  1  single-cycle pulse, new master-DLL code
lpf_code_in  in  5  master-DLL code
lpf_code  out  5  code driven to slave delay lines
strobe  out  1  slave-DL code load strobe
code_pending  out  1  a received code is not yet applied
dram_io_pad_enable  out  1  pad enable for the whole burst window
dram_io_drive_enable  out  1  output driver enable (writes only)
burst_length_four  out  1  registered BL of current/last burst
pad_pos_cnt  out  2  rising-edge write pointer
pad_neg_cnt  out  2  falling-edge write pointer
rd_capture_en  out  1  read data capture window
busy  out  1  state != IDLE

Behaviour:
- Reset (arst high, asynchronous): state=IDLE, idle_cnt=0, pending=0, lpf_code=0, pointers=0, burst_length_four=1; all other outputs 0.
- All outputs are Moore-decoded from registered state. Only cmd_ready is combinational: cmd_ready = (state==IDLE) & ~upd_go.
- upd_go = (state==IDLE) & pending & (idle_cnt>=IDLE_MIN).
- idle_cnt: +1 per IDLE cycle, saturates at 15, clears on any exit from IDLE.
- States:
  - IDLE: on upd_go go to CUPD (this has priority over cmd_valid). Else on an accepted command latch cmd_bl4 into burst_length_four and go to WPRE (write) or RWAIT (read).
  - WPRE: WR_PRE cycles, then WDATA.
  - WDATA: 2 (BL4) or 4 (BL8) cycles, then WPOST. pad_pos_cnt and pad_neg_cnt each +1 mod 4 at the end of every WDATA cycle.
  - WPOST: WR_POST cycles, then IDLE.
  - RWAIT: RD_LAT cycles, then RDATA.
  - RDATA: 2/4 cycles, then IDLE.
  - CUPD: STROBE_W cycles, then IDLE.
- Output decode:
  - pad_enable=1 in WPRE/WDATA/WPOST/RWAIT/RDATA.
  - drive_enable=1 in WPRE/WDATA/WPOST.
  - rd_capture_en=1 in RDATA.
  - strobe=1 in CUPD.
- Latency: command accepted at edge N; first controlled cycle is N+1. A write occupies WR_PRE+beats+WR_POST cycles; a read occupies RD_LAT+beats. No back-to-back bursts; the minimum gap is one IDLE cycle.
- Code path: lpf_code_vld loads lpf_code_in into pend_code and sets pending. Latest value wins.
- On the IDLE->CUPD edge: lpf_code<=pend_code and pending clears. If lpf_code_vld arrives in that same cycle, the new value is stored and pending stays 1; the old pend_code is the one applied.
- lpf_code is stable throughout CUPD.
- Pointers are never reset per burst; they wrap 3->0. Reads do not move them.
- Reset mid-operation: all outputs drop immediately; any in-flight burst and pending code are discarded.

Decomposition:
- Package bw_io_ddr_pkg: state enum (IDLE, WPRE, WDATA, WPOST, RWAIT, RDATA, CUPD); BEATS_BL4=2; BEATS_BL8=4; LPF_W=5; PTR_W=2.
- One sub-module: bw_io_ddr_code_upd. It holds pend_code, pending, idle_cnt and lpf_code, and produces upd_go.
- The main FSM and the shared per-state cycle counter stay in bw_io_ddr_lane_seq.

Test Plan:
- Write BL4 (defaults), accepted cycle 0 -> pad_enable and drive_enable high cycles 1-4, pointers 0->2, cmd_ready high again cycle 5.
- Read BL8, accepted cycle 0 -> pad_enable cycles 1-7, rd_capture_en cycles 4-7, drive_enable 0 throughout, pointers unchanged.
- Pointer wrap: write BL8, write BL4, write BL8 -> pointers after each burst 0, 2, 2 (10 mod 4).
- Code update: after reset, lpf_code_vld with 5'h0A at cycle 1, no commands -> strobe cycles 5-6, lpf_code=5'h0A from cycle 5, code_pending 0 from cycle 5. A second lpf_code_vld with 5'h11 at cycle 5 -> applied after another 4 IDLE cycles.
- Priority: pending code eligible while cmd_valid held high -> cmd_ready 0, CUPD runs STROBE_W cycles, command accepted on the first IDLE cycle after.
- arst asserted mid-WDATA -> drive_enable, pad_enable and pointers 0 with no rclk edge. After release: state IDLE, burst_length_four=1, cmd_ready 1.
